// File: rtl/bn_pkg.sv
// Shared definitions for the batch-norm vector unit.
// Contents:
//   - default widths for bn_vec_unit parameters
//   - beat_cfg_t: per-beat configuration carried down the pipeline
//   - round_shr:  round-half-up arithmetic right shift
//   - relu_sat:   ReLU followed by signed saturation, with saturation flag
// Helpers work on a 64-bit signed intermediate, so DATA_WIDTH+PARAM_WIDTH+1
// must not exceed 63 bits and OUT_WIDTH must be at most 63.
package bn_pkg;

    localparam int DEF_NUM_LANES   = 4;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_PARAM_WIDTH = 16;
    localparam int DEF_OUT_WIDTH   = 16;
    localparam int DEF_SHIFT_WIDTH = 5;

    // Shift field in the carried config; wide enough for any sensible SHIFT_WIDTH.
    localparam int CFG_SHIFT_W = 8;
    localparam int CALC_W      = 64;

    typedef struct packed {
        logic                   bn_en;
        logic                   relu_en;
        logic [CFG_SHIFT_W-1:0] shift;
    } beat_cfg_t;

    typedef struct packed {
        logic                     sat;
        logic signed [CALC_W-1:0] val;
    } sat_res_t;

    // Adds 2^(sh-1) before the arithmetic shift; a zero shift adds nothing.
    function automatic logic signed [CALC_W-1:0] round_shr(
        input logic signed [CALC_W-1:0] v,
        input logic [CFG_SHIFT_W-1:0]   sh
    );
        logic signed [CALC_W-1:0] bias;
        bias = '0;
        if (sh != '0) begin
            bias = 64'sd1 <<< (sh - CFG_SHIFT_W'(1));
        end
        return (v + bias) >>> sh;
    endfunction

    // ReLU comes first so a lane zeroed by it never reports saturation.
    function automatic sat_res_t relu_sat(
        input logic signed [CALC_W-1:0] v,
        input logic                     relu_en,
        input int                       out_w
    );
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        sat_res_t                 r;
        hi    = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (out_w - 1));
        r.sat = 1'b0;
        r.val = v;
        if (relu_en && (v < 0)) begin
            r.val = '0;
        end else if (v > hi) begin
            r.val = hi;
            r.sat = 1'b1;
        end else if (v < lo) begin
            r.val = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bn_lane.sv
// One batch-norm lane: S1 add, S2 multiply, S3 round/ReLU/saturate.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   en_s1/en_s2/en_s3    per-stage load enables shared by all lanes
//   bn_en                bn enable of the beat entering S1
//   relu_en_s3, shift_s3 config of the beat moving from S2 into S3
//   x, a, b              signed element, additive term, scale
//   y, sat               registered result and saturation flag
module bn_lane
    import bn_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int PARAM_WIDTH = DEF_PARAM_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_s1,
    input  logic                          en_s2,
    input  logic                          en_s3,
    input  logic                          bn_en,
    input  logic                          relu_en_s3,
    input  logic [CFG_SHIFT_W-1:0]        shift_s3,
    input  logic signed [DATA_WIDTH-1:0]  x,
    input  logic signed [PARAM_WIDTH-1:0] a,
    input  logic signed [PARAM_WIDTH-1:0] b,
    output logic signed [OUT_WIDTH-1:0]   y,
    output logic                          sat
);

    localparam int SUM_W  = DATA_WIDTH + 1;
    localparam int PROD_W = DATA_WIDTH + PARAM_WIDTH + 1;

    logic signed [SUM_W-1:0]       sum_q, sum_d;
    logic signed [PARAM_WIDTH-1:0] b_q, b_d;
    logic signed [PROD_W-1:0]      prod_q, prod_d;
    logic signed [OUT_WIDTH-1:0]   y_q, y_d;
    logic                          sat_q, sat_d;
    logic signed [SUM_W-1:0]       a_eff;
    logic signed [CALC_W-1:0]      rounded;
    sat_res_t                      res;
    logic                          unused_hi;

    // Bypass is folded into the datapath: a forced to 0 and b to 1, and the
    // carried shift is already 0 for bypass beats, so y = sat(relu(x)).
    always_comb begin
        a_eff   = bn_en ? SUM_W'(a) : '0;
        sum_d   = en_s1 ? (SUM_W'(x) + a_eff) : sum_q;
        b_d     = en_s1 ? (bn_en ? b : PARAM_WIDTH'(1)) : b_q;
        prod_d  = en_s2 ? (PROD_W'(sum_q) * PROD_W'(b_q)) : prod_q;
        rounded = round_shr(CALC_W'(prod_q), shift_s3);
        res     = relu_sat(rounded, relu_en_s3, OUT_WIDTH);
        y_d     = en_s3 ? res.val[OUT_WIDTH-1:0] : y_q;
        sat_d   = en_s3 ? res.sat : sat_q;
    end

    // Upper bits are guaranteed redundant after clamping.
    assign unused_hi = ^res.val[CALC_W-1:OUT_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            b_q    <= '0;
            prod_q <= '0;
            y_q    <= '0;
            sat_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            b_q    <= b_d;
            prod_q <= prod_d;
            y_q    <= y_d;
            sat_q  <= sat_d;
        end
    end

    assign y   = y_q;
    assign sat = sat_q;

endmodule

// File: rtl/bn_vec_unit.sv
// Vector batch-norm unit: NUM_LANES lanes of y = sat(relu(round((x+a)*b >> s)))
// behind a valid/ready handshake, 3-stage pipeline, one beat per cycle.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            input handshake
//   in_data, in_param_a/_b       packed lanes, lane 0 in the LSBs
//   cfg_bn_en/relu_en/shift      per-beat config, sampled on acceptance
//   out_valid/out_ready          output handshake
//   out_data, out_sat            packed results and per-lane saturation flags
//   stat_clr, sat_count          clear / count of output beats with any sat
module bn_vec_unit
    import bn_pkg::*;
#(
    parameter int NUM_LANES   = DEF_NUM_LANES,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int PARAM_WIDTH = DEF_PARAM_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_LANES*PARAM_WIDTH-1:0] in_param_a,
    input  logic [NUM_LANES*PARAM_WIDTH-1:0] in_param_b,
    input  logic                             cfg_bn_en,
    input  logic                             cfg_relu_en,
    input  logic [SHIFT_WIDTH-1:0]           cfg_shift,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_LANES*OUT_WIDTH-1:0]   out_data,
    output logic [NUM_LANES-1:0]             out_sat,
    input  logic                             stat_clr,
    output logic [31:0]                      sat_count
);

    logic       v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic       en_s1, en_s2, en_s3;
    beat_cfg_t  cfg_in, cfg1_q, cfg1_d, cfg2_q, cfg2_d;
    logic [31:0] sat_count_q, sat_count_d;
    logic       sat_hit;
    logic       unused_cfg;

    // A stage loads when it is empty or its content moves on this cycle, so
    // bubbles upstream of a stall are squeezed out instead of blocking input.
    always_comb begin
        en_s3 = !v3_q || out_ready;
        en_s2 = !v2_q || en_s3;
        en_s1 = !v1_q || en_s2;

        v1_d = en_s1 ? in_valid : v1_q;
        v2_d = en_s2 ? v1_q : v2_q;
        v3_d = en_s3 ? v2_q : v3_q;

        cfg_in.bn_en   = cfg_bn_en;
        cfg_in.relu_en = cfg_relu_en;
        // Bypass beats carry a zero shift so the lane needs no bypass mux at S3.
        cfg_in.shift   = cfg_bn_en ? CFG_SHIFT_W'(cfg_shift) : '0;
        cfg1_d = en_s1 ? cfg_in : cfg1_q;
        cfg2_d = en_s2 ? cfg1_q : cfg2_q;

        sat_hit     = v3_q && out_ready && (|out_sat);
        sat_count_d = sat_count_q;
        if (stat_clr) begin
            sat_count_d = '0;
        end else if (sat_hit && (sat_count_q != 32'hFFFF_FFFF)) begin
            sat_count_d = sat_count_q + 32'd1;
        end
    end

    assign unused_cfg = cfg2_q.bn_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            cfg1_q      <= '0;
            cfg2_q      <= '0;
            sat_count_q <= '0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            v3_q        <= v3_d;
            cfg1_q      <= cfg1_d;
            cfg2_q      <= cfg2_d;
            sat_count_q <= sat_count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            bn_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .PARAM_WIDTH(PARAM_WIDTH),
                .OUT_WIDTH  (OUT_WIDTH)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .en_s1     (en_s1),
                .en_s2     (en_s2),
                .en_s3     (en_s3),
                .bn_en     (cfg_bn_en),
                .relu_en_s3(cfg2_q.relu_en),
                .shift_s3  (cfg2_q.shift),
                .x         (in_data[gi*DATA_WIDTH +: DATA_WIDTH]),
                .a         (in_param_a[gi*PARAM_WIDTH +: PARAM_WIDTH]),
                .b         (in_param_b[gi*PARAM_WIDTH +: PARAM_WIDTH]),
                .y         (out_data[gi*OUT_WIDTH +: OUT_WIDTH]),
                .sat       (out_sat[gi])
            );
        end
    endgenerate

    assign in_ready  = en_s1;
    assign out_valid = v3_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_bn_vec_unit.sv
// Self-checking bench for bn_vec_unit: vector table, scoreboard queue,
// random backpressure stream, stat_clr priority and mid-stream reset.
module tb_bn_vec_unit;

    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic [63:0]   in_param_a;
    logic [63:0]   in_param_b;
    logic          cfg_bn_en;
    logic          cfg_relu_en;
    logic [4:0]    cfg_shift;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic [NL-1:0] out_sat;
    logic          stat_clr;
    logic [31:0]   sat_count;

    always #5 clk = ~clk;

    bn_vec_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_param_a (in_param_a),
        .in_param_b (in_param_b),
        .cfg_bn_en  (cfg_bn_en),
        .cfg_relu_en(cfg_relu_en),
        .cfg_shift  (cfg_shift),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .stat_clr   (stat_clr),
        .sat_count  (sat_count)
    );

    typedef struct packed {
        logic [63:0]   y;
        logic [NL-1:0] sat;
        logic [31:0]   acc;
        logic          chk_lat;
    } exp_t;

    typedef struct {
        int          x[NL];
        int          a[NL];
        int          b[NL];
        bit          bn;
        bit          relu;
        int          sh;
        int          y[NL];
        bit [NL-1:0] sat;
    } vec_t;

    exp_t   sb_q[$];
    vec_t   tbl[6];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    longint exp_sat_cnt = 0;
    bit     rand_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [63:0] pack(input int v[NL]);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < NL; i++) r[i*16 +: 16] = v[i][15:0];
        return r;
    endfunction

    // Reference lane arithmetic at full precision.
    function automatic void model_lane(input int x, input int a, input int b, input bit bn,
                                       input bit relu, input int sh,
                                       output logic [15:0] y, output bit s);
        longint v;
        v = bn ? (longint'(x) + longint'(a)) * longint'(b) : longint'(x);
        if (bn && sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
        s = 1'b0;
        if (relu && v < 0) v = 0;
        else if (v > 32767) begin v = 32767; s = 1'b1; end
        else if (v < -32768) begin v = -32768; s = 1'b1; end
        y = v[15:0];
    endfunction

    task automatic send(input logic [63:0] xd, input logic [63:0] ad, input logic [63:0] bd,
                        input bit bn, input bit relu, input int sh, input exp_t e, input bit push);
        int budget;
        in_data     = xd;
        in_param_a  = ad;
        in_param_b  = bd;
        cfg_bn_en   = bn;
        cfg_relu_en = relu;
        cfg_shift   = sh[4:0];
        in_valid    = 1'b1;
        budget      = 500;
        @(negedge clk);
        while (!in_ready && budget > 0) begin
            budget--;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready stayed 0, need 1");
        end else if (push) begin
            e.acc = cyc;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input int k, input bit push);
        exp_t e;
        e.y       = pack(tbl[k].y);
        e.sat     = tbl[k].sat;
        e.acc     = '0;
        e.chk_lat = 1'b1;
        send(pack(tbl[k].x), pack(tbl[k].a), pack(tbl[k].b), tbl[k].bn, tbl[k].relu,
             tbl[k].sh, e, push);
    endtask

    task automatic drain();
        int budget;
        budget = 2000;
        while (sb_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d beats left, need 0", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Random backpressure, changed just after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: scoreboard pops and stall-stability checks.
    initial begin
        exp_t        e;
        logic        prev_stall;
        logic [63:0] held_d;
        logic [3:0]  held_s;
        prev_stall = 1'b0;
        held_d     = '0;
        held_s     = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 64'(out_valid), 64'd1);
                    check("stall_data", out_data, held_d);
                    check("stall_sat", 64'(out_sat), 64'(held_s));
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: got=%h, need no beat", out_data);
                    end else begin
                        e = sb_q.pop_front();
                        check("out_data", out_data, e.y);
                        check("out_sat", 64'(out_sat), 64'(e.sat));
                        if (e.chk_lat) check("latency", 64'(cyc - int'(e.acc)), 64'd3);
                        $display("beat out data=%h sat=%b", out_data, out_sat);
                        if (|e.sat) exp_sat_cnt++;
                    end
                end
                prev_stall = out_valid && !out_ready;
                held_d     = out_data;
                held_s     = out_sat;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   xs[NL];
        int   as[NL];
        int   bs[NL];
        int   budget;
        bit   bn;
        bit   relu;
        int   sh;

        tbl[0].x = '{100, 5, -5, 100};       tbl[0].a = '{-20, 0, 0, -20};
        tbl[0].b = '{3, 3, 3, 3};            tbl[0].bn = 1; tbl[0].relu = 0; tbl[0].sh = 1;
        tbl[0].y = '{120, 8, -7, 120};       tbl[0].sat = 4'b0000;

        tbl[1].x = '{32767, 32767, 0, -1};   tbl[1].a = '{32767, 32767, 0, -1};
        tbl[1].b = '{32767, -32768, 5, 2};   tbl[1].bn = 1; tbl[1].relu = 0; tbl[1].sh = 0;
        tbl[1].y = '{32767, -32768, 0, -4};  tbl[1].sat = 4'b0011;

        tbl[2].x = '{-5, 7, 0, -32768};      tbl[2].a = '{1000, 1000, 1000, 1000};
        tbl[2].b = '{7, 7, 7, 7};            tbl[2].bn = 0; tbl[2].relu = 1; tbl[2].sh = 2;
        tbl[2].y = '{0, 7, 0, 0};            tbl[2].sat = 4'b0000;

        tbl[3].x = '{-32768, 200, -3, 10};   tbl[3].a = '{-32768, 0, 0, 5};
        tbl[3].b = '{32767, 200, 1, -2};     tbl[3].bn = 1; tbl[3].relu = 1; tbl[3].sh = 0;
        tbl[3].y = '{0, 32767, 0, 0};        tbl[3].sat = 4'b0010;

        tbl[4].x = '{7, -8, -9, 1000};       tbl[4].a = '{1, 0, 0, 0};
        tbl[4].b = '{1, 1, 1, 100};          tbl[4].bn = 1; tbl[4].relu = 0; tbl[4].sh = 4;
        tbl[4].y = '{1, 0, -1, 6250};        tbl[4].sat = 4'b0000;

        tbl[5].x = '{-5, 32767, -32768, 1};  tbl[5].a = '{3, 3, 3, 3};
        tbl[5].b = '{9, 9, 9, 9};            tbl[5].bn = 0; tbl[5].relu = 0; tbl[5].sh = 3;
        tbl[5].y = '{-5, 32767, -32768, 1};  tbl[5].sat = 4'b0000;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stat_clr = 1'b0;
        in_data = '0; in_param_a = '0; in_param_b = '0;
        cfg_bn_en = 1'b0; cfg_relu_en = 1'b0; cfg_shift = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_sat", 64'(out_sat), 64'd0);
        check("rst_sat_count", 64'(sat_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Table vectors, back to back with out_ready held high.
        for (int k = 0; k < 6; k++) send_vec(k, 1'b1);
        in_valid = 1'b0;
        drain();
        @(negedge clk);
        check("sat_count_table", 64'(sat_count), 64'(exp_sat_cnt));

        // stat_clr clears the counter.
        @(posedge clk); #1 stat_clr = 1'b1;
        @(posedge clk); #1 stat_clr = 1'b0;
        exp_sat_cnt = 0;
        @(negedge clk);
        check("stat_clr", 64'(sat_count), 64'd0);

        // stat_clr wins over a same-cycle saturating transfer.
        @(posedge clk); #1 out_ready = 1'b0;
        e.y = pack(tbl[1].y); e.sat = tbl[1].sat; e.acc = '0; e.chk_lat = 1'b0;
        send(pack(tbl[1].x), pack(tbl[1].a), pack(tbl[1].b), 1'b1, 1'b0, 0, e, 1'b1);
        in_valid = 1'b0;
        budget = 50;
        @(negedge clk);
        while (!out_valid && budget > 0) begin budget--; @(negedge clk); end
        check("prio_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1 stat_clr = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 stat_clr = 1'b0;
        @(negedge clk);
        check("stat_clr_priority", 64'(sat_count), 64'd0);
        exp_sat_cnt = 0;

        // Random stream under random backpressure.
        rand_mode = 1'b1;
        for (int n = 0; n < 20; n++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            bn   = 1'($urandom_range(0, 1));
            relu = 1'($urandom_range(0, 1));
            sh   = $urandom_range(0, 20);
            e.sat = '0; e.acc = '0; e.chk_lat = 1'b0;
            for (int i = 0; i < NL; i++) begin
                logic [15:0] yl;
                bit          sl;
                xs[i] = $urandom_range(0, 65535) - 32768;
                as[i] = $urandom_range(0, 65535) - 32768;
                bs[i] = $urandom_range(0, 65535) - 32768;
                model_lane(xs[i], as[i], bs[i], bn, relu, sh, yl, sl);
                e.y[i*16 +: 16] = yl;
                e.sat[i]        = sl;
            end
            send(pack(xs), pack(as), pack(bs), bn, relu, sh, e, 1'b1);
        end
        in_valid = 1'b0;
        drain();
        rand_mode = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("sat_count_stream", 64'(sat_count), 64'(exp_sat_cnt));

        // Mid-stream reset with three beats stalled in the pipeline.
        @(posedge clk); #1 out_ready = 1'b0;
        for (int k = 1; k < 4; k++) send_vec(k, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_sat_cnt = 0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_sat_count", 64'(sat_count), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
        send_vec(0, 1'b1);
        in_valid = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
